// File: rtl/aemb2_mem_arb.sv
// aemb2_mem_arb
// Shares one single-port Wishbone memory slave between the AEMB2 instruction
// bus (read-only) and data bus (read/write). Idle-to-grant is registered and
// ties are broken round-robin. While a grant is held the slave-side signals
// are a combinational mux of the granted master. A per-transfer watchdog
// terminates a hung slave cycle with a poisoned ack and sets a sticky flag.
module aemb2_mem_arb #(
    parameter int AW  = 16,
    parameter int TMO = 255,
    parameter int TOW = 8
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_ni,
    input  logic [AW-3:0] iwb_adr_i,
    input  logic          iwb_stb_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    input  logic [AW-3:0] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic          dwb_wre_i,
    input  logic          dwb_stb_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic [AW-3:0] mem_adr_o,
    output logic [31:0]   mem_dat_o,
    output logic [3:0]    mem_sel_o,
    output logic          mem_wre_o,
    output logic          mem_stb_o,
    output logic          mem_cyc_o,
    input  logic [31:0]   mem_dat_i,
    input  logic          mem_ack_i,
    output logic [1:0]    gnt_o,
    output logic          tmo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IGNT = 2'd1,
        ST_DGNT = 2'd2
    } state_t;

    // Watchdog fires on the TMO-th granted cycle, i.e. when the count of
    // already-elapsed granted cycles equals TMO-1.
    localparam logic [TOW-1:0] TMO_LAST = TOW'(TMO - 1);
    localparam logic [31:0]    TMO_DATA = 32'hDEADBEEF;

    state_t         state_r;
    state_t         state_nx_s;
    logic           last_dwb_r;   // 1: data bus held the most recent grant
    logic [TOW-1:0] wdt_r;
    logic           tmo_r;

    logic           gstb_s;
    logic           busy_s;
    logic           done_s;
    logic           abort_s;
    logic           fire_s;
    logic           end_s;
    logic [31:0]    rd_dat_s;

    // Decode the events that end a granted transfer (ack, abort, watchdog).
    always_comb begin
        gstb_s = 1'b0;
        case (state_r)
            ST_IGNT: gstb_s = iwb_stb_i;
            ST_DGNT: gstb_s = dwb_stb_i;
            default: gstb_s = 1'b0;
        endcase
        busy_s  = (state_r != ST_IDLE);
        done_s  = busy_s & mem_ack_i;
        abort_s = busy_s & ~mem_ack_i & ~gstb_s;
        fire_s  = busy_s & ~mem_ack_i & gstb_s & (wdt_r == TMO_LAST);
        end_s   = done_s | abort_s | fire_s;
    end

    // State register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state: round-robin on ties, back to idle whenever a transfer ends.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iwb_stb_i && dwb_stb_i) begin
                    state_nx_s = last_dwb_r ? ST_IGNT : ST_DGNT;
                end else if (iwb_stb_i) begin
                    state_nx_s = ST_IGNT;
                end else if (dwb_stb_i) begin
                    state_nx_s = ST_DGNT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_IGNT, ST_DGNT: begin
                if (end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Round-robin pointer, per-transfer watchdog and sticky timeout flag.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            last_dwb_r <= 1'b0;
            wdt_r      <= {TOW{1'b0}};
            tmo_r      <= 1'b0;
        end else if (end_s) begin
            last_dwb_r <= (state_r == ST_DGNT);
            wdt_r      <= {TOW{1'b0}};
            tmo_r      <= tmo_r | fire_s;
        end else if (busy_s) begin
            wdt_r      <= wdt_r + {{(TOW-1){1'b0}}, 1'b1};
        end else begin
            wdt_r      <= {TOW{1'b0}};
        end
    end

    // Slave-side mux and master acks; a watchdog ack carries poisoned data.
    always_comb begin
        mem_adr_o = {(AW-2){1'b0}};
        mem_dat_o = 32'h0000_0000;
        mem_sel_o = 4'h0;
        mem_wre_o = 1'b0;
        mem_stb_o = 1'b0;
        mem_cyc_o = 1'b0;
        iwb_ack_o = 1'b0;
        dwb_ack_o = 1'b0;
        gnt_o     = 2'b00;
        rd_dat_s  = fire_s ? TMO_DATA : mem_dat_i;
        case (state_r)
            ST_IGNT: begin
                mem_adr_o = iwb_adr_i;
                mem_sel_o = 4'hF;
                mem_stb_o = iwb_stb_i;
                mem_cyc_o = 1'b1;
                iwb_ack_o = mem_ack_i | fire_s;
                gnt_o     = 2'b01;
            end
            ST_DGNT: begin
                mem_adr_o = dwb_adr_i;
                mem_dat_o = dwb_dat_i;
                mem_sel_o = dwb_sel_i;
                mem_wre_o = dwb_wre_i;
                mem_stb_o = dwb_stb_i;
                mem_cyc_o = 1'b1;
                dwb_ack_o = mem_ack_i | fire_s;
                gnt_o     = 2'b10;
            end
            default: begin
                // Idle: slave bus parked at zero, slave acks ignored.
                gnt_o = 2'b00;
            end
        endcase
        iwb_dat_o = rd_dat_s;
        dwb_dat_o = rd_dat_s;
        tmo_o     = tmo_r;
    end

endmodule

// File: tb/tb_aemb2_mem_arb.sv
// Bench for aemb2_mem_arb: RAM slave with variable latency, two bus masters,
// and a scoreboard monitor checking returned data and arbitration order.
module tb_aemb2_mem_arb;
    localparam int AW  = 16;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] iwb_adr_i = '0;
    logic        iwb_stb_i = 1'b0;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;
    logic [13:0] dwb_adr_i = '0;
    logic [31:0] dwb_dat_i = '0;
    logic [3:0]  dwb_sel_i = '0;
    logic        dwb_wre_i = 1'b0;
    logic        dwb_stb_i = 1'b0;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic [3:0]  mem_sel_o;
    logic        mem_wre_o, mem_stb_o, mem_cyc_o;
    logic [31:0] mem_dat_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [1:0]  gnt_o;
    logic        tmo_o;

    always #5 clk = ~clk;

    aemb2_mem_arb #(.AW(AW), .TMO(TMO), .TOW(8)) dut (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .iwb_adr_i(iwb_adr_i), .iwb_stb_i(iwb_stb_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_sel_i(dwb_sel_i), .dwb_wre_i(dwb_wre_i),
        .dwb_stb_i(dwb_stb_i), .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o), .mem_wre_o(mem_wre_o),
        .mem_stb_o(mem_stb_o), .mem_cyc_o(mem_cyc_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
        .gnt_o(gnt_o), .tmo_o(tmo_o)
    );

    typedef struct packed {
        logic        wr;
        logic [13:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } xact_t;

    logic [31:0] ram     [0:16383];   // slave contents
    logic [31:0] ref_mem [0:16383];   // reference view of memory
    xact_t iwb_q[$];
    xact_t dwb_q[$];
    int checks = 0;
    int failures = 0;
    int iwb_acks = 0;
    int dwb_acks = 0;
    bit noack = 1'b1;
    bit rand_lat = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave: ack after 'lat' extra granted cycles, reads/writes its RAM on ack.
    initial begin
        int lat, scnt;
        lat = 1; scnt = 0;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h3C00_0000 + i * 7;
        ram[16] = 32'hB800_0000;
        forever begin
            @(posedge clk); #2;
            if (rst_n && mem_cyc_o && mem_stb_o && !noack && !mem_ack_i) begin
                if (scnt >= lat) begin
                    mem_ack_i = 1'b1;
                    mem_dat_i = ram[mem_adr_o];
                    if (mem_wre_o) ram[mem_adr_o] = merge(ram[mem_adr_o], mem_dat_o, mem_sel_o);
                    scnt = 0;
                    lat = rand_lat ? int'($urandom_range(0, 2)) : 1;
                end else begin
                    scnt++;
                    mem_dat_i = $urandom;
                end
            end else begin
                mem_ack_i = 1'b0;
                mem_dat_i = $urandom;
                scnt = 0;
            end
        end
    end

    // Monitor: pops expected responses on acks and checks arbitration order.
    initial begin
        logic [1:0] prev_gnt, last_g, exp_g;
        logic prev_i, prev_d;
        xact_t e;
        prev_gnt = 2'b00; last_g = 2'b01; prev_i = 1'b0; prev_d = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (iwb_ack_o || dwb_ack_o) check("ack_exclusive", 32'(iwb_ack_o & dwb_ack_o), 32'd0);
                if (iwb_ack_o) begin
                    iwb_acks++;
                    if (iwb_q.size() == 0) check("iwb_unexpected_ack", 32'd1, 32'd0);
                    else begin e = iwb_q.pop_front(); check("iwb_data", iwb_dat_o, e.dat); end
                end
                if (dwb_ack_o) begin
                    dwb_acks++;
                    if (dwb_q.size() == 0) check("dwb_unexpected_ack", 32'd1, 32'd0);
                    else begin
                        e = dwb_q.pop_front();
                        if (!e.wr) check("dwb_data", dwb_dat_o, e.dat);
                    end
                end
                if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                    if (prev_i && prev_d) exp_g = (last_g == 2'b10) ? 2'b01 : 2'b10;
                    else exp_g = prev_d ? 2'b10 : 2'b01;
                    check("grant_order", 32'(gnt_o), 32'(exp_g));
                    last_g = gnt_o;
                    if (gnt_o == 2'b01 && iwb_q.size() > 0) begin
                        check("iwb_mem_adr", 32'(mem_adr_o), 32'(iwb_q[0].adr));
                        check("iwb_wre_sel", {27'd0, mem_wre_o, mem_sel_o}, 32'h0000_000F);
                    end
                    if (gnt_o == 2'b10 && dwb_q.size() > 0) begin
                        check("dwb_mem_adr", 32'(mem_adr_o), 32'(dwb_q[0].adr));
                        check("dwb_wre_sel", {27'd0, mem_wre_o, mem_sel_o}, {27'd0, dwb_q[0].wr, dwb_q[0].sel});
                        if (dwb_q[0].wr) check("dwb_mem_dat", mem_dat_o, dwb_q[0].dat);
                    end
                end
                prev_gnt = gnt_o;
            end else begin
                prev_gnt = 2'b00;
            end
            prev_i = iwb_stb_i;
            prev_d = dwb_stb_i;
        end
    end

    task automatic iwb_xfer(input logic [13:0] a, input bit tmo_exp, output int gcy);
        xact_t e;
        bit got;
        e.wr = 1'b0; e.adr = a; e.sel = 4'hF;
        e.dat = tmo_exp ? 32'hDEADBEEF : ref_mem[a];
        iwb_q.push_back(e);
        iwb_adr_i = a; iwb_stb_i = 1'b1; gcy = 0; got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (gnt_o == 2'b01) gcy++;
            if (iwb_ack_o) got = 1'b1;
        end
        if (!got) begin check("iwb_ack_wait", 32'd0, 32'd1); void'(iwb_q.pop_back()); end
        @(posedge clk); #1;
        iwb_stb_i = 1'b0;
    endtask

    task automatic dwb_xfer(input logic [13:0] a, input bit wr, input logic [31:0] d, input logic [3:0] sel);
        xact_t e;
        bit got;
        e.wr = wr; e.adr = a; e.sel = sel;
        if (wr) begin e.dat = d; ref_mem[a] = merge(ref_mem[a], d, sel); end
        else e.dat = ref_mem[a];
        dwb_q.push_back(e);
        dwb_adr_i = a; dwb_dat_i = d; dwb_sel_i = sel; dwb_wre_i = wr; dwb_stb_i = 1'b1; got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (dwb_ack_o) got = 1'b1;
        end
        if (!got) begin check("dwb_ack_wait", 32'd0, 32'd1); void'(dwb_q.pop_back()); end
        @(posedge clk); #1;
        dwb_stb_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    // Stimulus.
    initial begin
        int g, i0, d0;
        bit got;
        logic [31:0] old;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h3C00_0000 + i * 7;
        ref_mem[16] = 32'hB800_0000;

        // Reset held with both masters requesting.
        iwb_stb_i = 1'b1; dwb_stb_i = 1'b1; noack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {24'd0, iwb_ack_o, dwb_ack_o, mem_stb_o, mem_cyc_o, gnt_o, tmo_o, mem_wre_o}, 32'd0);
        end
        check("reset_mem_bus", {mem_sel_o, 14'd0} | 32'(mem_adr_o) | mem_dat_o, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("first_tie_dgnt", 32'(gnt_o), 32'(2'b10));
        @(posedge clk); #1 iwb_stb_i = 1'b0; dwb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 noack = 1'b0;

        // Single instruction read with one-cycle slave latency.
        iwb_xfer(14'h0010, 1'b0, g);
        check("iwb_ack_cycle", 32'(g), 32'd2);

        // Byte write on lane 1, then read back.
        old = ref_mem[256];
        dwb_xfer(14'h0100, 1'b1, 32'h0000_AB00, 4'h2);
        check("byte_lane_ram", ram[256], {old[31:16], 8'hAB, old[7:0]});
        dwb_xfer(14'h0100, 1'b0, 32'h0, 4'hF);

        // Contention: both masters hold requests for four transfers each.
        i0 = iwb_acks; d0 = dwb_acks;
        fork
            for (int k = 0; k < 4; k++) iwb_xfer(14'(k), 1'b0, g);
            for (int k = 0; k < 4; k++) dwb_xfer(14'h0104 + 14'(k), 1'b0, 32'h0, 4'hF);
        join
        check("contention_iwb_acks", 32'(iwb_acks - i0), 32'd4);
        check("contention_dwb_acks", 32'(dwb_acks - d0), 32'd4);

        // Abort: data master drops its request one cycle after the grant.
        d0 = dwb_acks;
        noack = 1'b1;
        dwb_adr_i = 14'h0110; dwb_wre_i = 1'b0; dwb_sel_i = 4'hF; dwb_stb_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (gnt_o == 2'b10) got = 1'b1;
        end
        check("abort_grant_seen", 32'(got), 32'd1);
        @(posedge clk); #1 dwb_stb_i = 1'b0; noack = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'(gnt_o), 32'd0);
        iwb_xfer(14'h0020, 1'b0, g);
        check("abort_no_dwb_ack", 32'(dwb_acks - d0), 32'd0);

        // Watchdog: slave never acks the instruction read.
        check("tmo_clear_before", 32'(tmo_o), 32'd0);
        noack = 1'b1;
        iwb_xfer(14'h0008, 1'b1, g);
        check("tmo_ack_cycle", 32'(g), 32'(TMO));
        check("tmo_set", 32'(tmo_o), 32'd1);
        noack = 1'b0;
        iwb_xfer(14'h0009, 1'b0, g);
        dwb_xfer(14'h0120, 1'b1, 32'h1234_5678, 4'hF);
        check("tmo_sticky", 32'(tmo_o), 32'd1);

        // Randomized traffic with random slave latency.
        rand_lat = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                iwb_xfer(14'($urandom_range(0, 63)), 1'b0, g);
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                dwb_xfer(14'h0100 + 14'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                         $urandom, 4'($urandom_range(1, 15)));
            end
        join

        repeat (4) @(posedge clk);
        check("queues_drained", 32'(iwb_q.size() + dwb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
